// File: rtl/ntcrack_host_driver.sv
// ntcrack_host_driver: streams target hashes byte-serially into the cracker, issues go, and collects 21-byte match reports.
module ntcrack_host_driver #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hash_valid,
  output logic             hash_ready,
  input  logic [127:0]     hash_data,
  input  logic             hash_last,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [159:0]     result_password,
  output logic [4:0]       result_len,
  output logic             result_len_err,
  output logic [7:0]       new_hash_byte,
  output logic             store_hash_byte,
  output logic             go,
  input  logic             your_turn,
  input  logic             match_found,
  input  logic [7:0]       password_byte,
  output logic             cracking,
  output logic [CNT_W-1:0] hash_count,
  output logic [CNT_W-1:0] match_count
);
  localparam logic [2:0] IDLE = 3'd0, L_WAIT = 3'd1, L_STB = 3'd2, L_NEXT = 3'd3,
                         G_WAIT = 3'd4, G_STB = 3'd5, CRACK = 3'd6, R_ACK = 3'd7;
  logic [2:0]   state;
  logic [4:0]   idx;
  logic [127:0] hash_r;
  logic         last_r;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state           <= IDLE;
      idx             <= '0;
      hash_r          <= '0;
      last_r          <= 1'b0;
      hash_ready      <= 1'b0;
      new_hash_byte   <= '0;
      store_hash_byte <= 1'b0;
      go              <= 1'b0;
      cracking        <= 1'b0;
      result_valid    <= 1'b0;
      result_password <= '0;
      result_len      <= '0;
      result_len_err  <= 1'b0;
      hash_count      <= '0;
      match_count     <= '0;
    end else begin
      if (result_valid && result_ready) begin
        result_valid <= 1'b0;
        match_count  <= &match_count ? match_count : match_count + 1'b1;
      end
      case (state)
        IDLE:
          if (hash_valid && hash_ready) begin
            hash_r     <= hash_data;
            last_r     <= hash_last;
            idx        <= '0;
            hash_ready <= 1'b0;
            state      <= L_WAIT;
          end else hash_ready <= 1'b1;
        L_WAIT:
          if (your_turn) begin
            new_hash_byte   <= hash_r[8*idx[3:0] +: 8];
            store_hash_byte <= 1'b1;
            state           <= L_STB;
          end
        L_STB:
          if (!your_turn) begin
            store_hash_byte <= 1'b0;
            state           <= L_NEXT;
          end
        L_NEXT:
          if (idx == 5'd15) begin
            hash_count <= &hash_count ? hash_count : hash_count + 1'b1;
            state      <= last_r ? G_WAIT : IDLE;
          end else begin
            idx   <= idx + 1'b1;
            state <= L_WAIT;
          end
        G_WAIT:
          if (your_turn) begin
            go    <= 1'b1;
            state <= G_STB;
          end
        G_STB:
          if (!your_turn) begin
            go       <= 1'b0;
            cracking <= 1'b1;
            idx      <= '0;
            state    <= CRACK;
          end
        // a pending undelivered report holds off the ack, stalling the cracker
        CRACK:
          if (your_turn && match_found && !result_valid) begin
            if (idx == 5'd20) {result_len_err, result_len} <= {|password_byte[7:5], password_byte[4:0]};
            else result_password[8*idx +: 8] <= password_byte;
            go    <= 1'b1;
            state <= R_ACK;
          end
        R_ACK:
          if (!your_turn) begin
            go <= 1'b0;
            if (idx == 5'd20) result_valid <= 1'b1;
            idx   <= idx == 5'd20 ? 5'd0 : idx + 1'b1;
            state <= CRACK;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_ntcrack_host_driver.sv
// tb_ntcrack_host_driver: behavioural cracker model plus scoreboard for the host driver.
module tb_ntcrack_host_driver;
  logic clk = 0, rst = 0;
  logic hash_valid = 0, hash_ready, hash_last = 0;
  logic [127:0] hash_data = '0;
  logic result_valid, result_ready = 1, result_len_err;
  logic [159:0] result_password;
  logic [4:0] result_len;
  logic [7:0] new_hash_byte, password_byte = '0;
  logic store_hash_byte, go, cracking;
  logic your_turn = 0, match_found = 0;
  logic [15:0] hash_count, match_count;
  int total = 0, bad = 0;
  int go_rises = 0, viol = 0;
  logic [7:0] obs_q[$];
  logic [165:0] rep_q[$];

  ntcrack_host_driver #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .hash_valid(hash_valid), .hash_ready(hash_ready), .hash_data(hash_data),
    .hash_last(hash_last), .result_valid(result_valid), .result_ready(result_ready),
    .result_password(result_password), .result_len(result_len), .result_len_err(result_len_err),
    .new_hash_byte(new_hash_byte), .store_hash_byte(store_hash_byte), .go(go), .your_turn(your_turn),
    .match_found(match_found), .password_byte(password_byte), .cracking(cracking),
    .hash_count(hash_count), .match_count(match_count));

  always #5 clk = ~clk;

  logic sp = 0, gp = 0, rvp = 0;
  logic [7:0] bp = '0;
  logic [165:0] rp = '0;
  wire [165:0] cur = {result_len_err, result_len, result_password};
  always @(negedge clk) begin
    if (rst) begin
      sp = 0; gp = 0; rvp = 0; bp = '0;
    end else begin
      if (store_hash_byte && !sp) obs_q.push_back(new_hash_byte);
      if (!(store_hash_byte && !sp) && new_hash_byte !== bp) viol++;
      if (store_hash_byte && go) viol++;
      if (store_hash_byte && hash_ready) viol++;
      if (go && !gp) go_rises++;
      if (result_valid && rvp && cur !== rp) viol++;
      if (result_valid && result_ready) rep_q.push_back(cur);
      sp = store_hash_byte; gp = go; rvp = result_valid; bp = new_hash_byte; rp = cur;
    end
  end

  function automatic logic [165:0] exp_rep(input logic [167:0] r);
    return {|r[167:165], r[164:160], r[159:0]};
  endfunction

  function automatic logic [167:0] rand_rep(input logic [7:0] lenb);
    logic [167:0] r;
    for (int k = 0; k < 20; k++) r[8*k +: 8] = 8'($urandom_range(32, 126));
    r[167:160] = lenb;
    return r;
  endfunction

  task automatic wait_out(input int sel, input logic v, input int lim, output bit ok);
    int n = 0;
    ok = 0;
    while (!ok && n < lim) begin
      @(negedge clk);
      n++;
      if ((sel == 0 ? store_hash_byte : sel == 1 ? go : sel == 2 ? result_valid : hash_ready) === v) ok = 1;
    end
  endtask

  task automatic do_reset;
    @(posedge clk) #1;
    rst = 1; your_turn = 0; match_found = 0; hash_valid = 0; result_ready = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic send_hash(input logic [127:0] h, input logic last, output bit ok);
    wait_out(3, 1, 50, ok);
    @(posedge clk) #1;
    hash_valid = 1; hash_data = h; hash_last = last;
    @(posedge clk) #1;
    hash_valid = 0;
  endtask

  task automatic cr_take(output bit ok);
    bit a, b;
    @(posedge clk) #1 your_turn = 1;
    wait_out(0, 1, 50, a);
    @(posedge clk) #1 your_turn = 0;
    wait_out(0, 0, 50, b);
    ok = a && b;
  endtask

  task automatic load_hash(input logic [127:0] h, input logic last, output bit ok);
    bit o;
    send_hash(h, last, ok);
    for (int k = 0; k < 16; k++) begin
      cr_take(o);
      ok &= o;
    end
  endtask

  task automatic cr_go(output bit ok);
    bit a, b;
    @(posedge clk) #1 your_turn = 1;
    wait_out(1, 1, 50, a);
    @(posedge clk) #1 your_turn = 0;
    wait_out(1, 0, 50, b);
    ok = a && b;
  endtask

  task automatic cr_rbyte(input logic [7:0] v, output bit ok);
    bit a, b;
    @(posedge clk) #1;
    your_turn = 1; match_found = 1; password_byte = v;
    wait_out(1, 1, 50, a);
    @(posedge clk) #1;
    your_turn = 0; match_found = 0;
    wait_out(1, 0, 50, b);
    ok = a && b;
  endtask

  task automatic cr_report(input logic [167:0] r, output bit ok);
    bit o;
    ok = 1;
    for (int k = 0; k < 21; k++) begin
      cr_rbyte(r[8*k +: 8], o);
      ok &= o;
    end
  endtask

  task automatic test_reset;
    bit ok;
    @(posedge clk) #1 rst = 1;
    @(negedge clk);
    total++;
    if ({hash_ready, store_hash_byte, go, cracking, result_valid} !== 5'b0) begin
      bad++; $display("FAIL reset_flags: got %b want 00000", {hash_ready, store_hash_byte, go, cracking, result_valid});
    end
    total++;
    if ({hash_count, match_count, new_hash_byte, result_len, result_len_err} !== '0) begin
      bad++; $display("FAIL reset_values: got hc=%0d mc=%0d b=%h len=%0d", hash_count, match_count, new_hash_byte, result_len);
    end
    @(posedge clk) #1 rst = 0;
    wait_out(3, 1, 5, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL reset_ready: got hash_ready=%b want 1", hash_ready); end
  endtask

  task automatic test_single_hash;
    logic [127:0] h;
    int base = obs_q.size(), g0 = go_rises, errs = 0;
    bit ok, ok2;
    for (int k = 0; k < 16; k++) h[8*k +: 8] = 8'(k);
    load_hash(h, 1, ok);
    cr_go(ok2);
    repeat (2) @(negedge clk);
    total++;
    if (!(ok && ok2)) begin bad++; $display("FAIL single_handshake: got ok=%b want 1", ok && ok2); end
    total++;
    if (obs_q.size() - base !== 16) begin bad++; $display("FAIL single_nstores: got %0d want 16", obs_q.size() - base); end
    else begin
      for (int k = 0; k < 16; k++) if (obs_q[base+k] !== h[8*k +: 8]) errs++;
      total++;
      if (errs != 0) begin bad++; $display("FAIL single_bytes: got %0d wrong want 0", errs); end
    end
    total++;
    if (go_rises - g0 !== 1) begin bad++; $display("FAIL single_go: got %0d want 1", go_rises - g0); end
    total++;
    if ({hash_count, cracking, hash_ready} !== {16'd1, 1'b1, 1'b0}) begin
      bad++; $display("FAIL single_status: got hc=%0d cr=%b hr=%b want 1 1 0", hash_count, cracking, hash_ready);
    end
  endtask

  task automatic test_match_abc;
    logic [167:0] r;
    int g0 = go_rises, n0 = rep_q.size();
    bit ok;
    for (int k = 0; k < 20; k++) r[8*k +: 8] = 8'h20;
    r[23:0] = 24'h636261;
    r[167:160] = 8'h03;
    cr_report(r, ok);
    repeat (3) @(negedge clk);
    total++;
    if (!ok || go_rises - g0 !== 21) begin bad++; $display("FAIL abc_acks: got %0d want 21", go_rises - g0); end
    total++;
    if (rep_q.size() !== n0 + 1) begin bad++; $display("FAIL abc_delivered: got %0d want %0d", rep_q.size(), n0 + 1); end
    else begin
      total++;
      if (rep_q[n0] !== exp_rep(r)) begin bad++; $display("FAIL abc_report: got %h want %h", rep_q[n0], exp_rep(r)); end
    end
    total++;
    if ({result_password[23:0], result_len, result_len_err} !== {24'h636261, 5'd3, 1'b0}) begin
      bad++; $display("FAIL abc_fields: got %h len=%0d err=%b want 636261 3 0", result_password[23:0], result_len, result_len_err);
    end
    total++;
    if (match_count !== 16'd1 || result_valid !== 1'b0) begin
      bad++; $display("FAIL abc_count: got mc=%0d rv=%b want 1 0", match_count, result_valid);
    end
  endtask

  task automatic test_backpressure;
    logic [167:0] a, b;
    int g0, n0 = rep_q.size();
    bit ok, o;
    a = rand_rep(8'($urandom_range(0, 20)));
    b = rand_rep(8'($urandom_range(0, 20)));
    @(posedge clk) #1 result_ready = 0;
    cr_report(a, ok);
    @(posedge clk) #1;
    your_turn = 1; match_found = 1; password_byte = b[7:0];
    g0 = go_rises;
    repeat (50) @(negedge clk);
    total++;
    if (go_rises !== g0 || go !== 1'b0) begin bad++; $display("FAIL bp_stall: got %0d acks want 0", go_rises - g0); end
    total++;
    if (result_valid !== 1'b1 || cur !== exp_rep(a)) begin
      bad++; $display("FAIL bp_hold: got rv=%b %h want 1 %h", result_valid, cur, exp_rep(a));
    end
    @(posedge clk) #1 result_ready = 1;
    for (int k = 0; k < 21; k++) begin
      cr_rbyte(b[8*k +: 8], o);
      ok &= o;
    end
    repeat (3) @(negedge clk);
    total++;
    if (!ok || rep_q.size() !== n0 + 2) begin bad++; $display("FAIL bp_count: got %0d reports want %0d", rep_q.size() - n0, 2); end
    else begin
      total++;
      if (rep_q[n0] !== exp_rep(a) || rep_q[n0+1] !== exp_rep(b)) begin
        bad++; $display("FAIL bp_order: got %h %h want %h %h", rep_q[n0], rep_q[n0+1], exp_rep(a), exp_rep(b));
      end
    end
    total++;
    if (match_count !== 16'd3) begin bad++; $display("FAIL bp_match_count: got %0d want 3", match_count); end
  endtask

  task automatic test_ignored_pulse;
    logic [167:0] r;
    int g0 = go_rises, n0 = rep_q.size();
    bit ok;
    @(posedge clk) #1;
    your_turn = 1; match_found = 0; password_byte = 8'hFF;
    repeat (4) @(negedge clk);
    @(posedge clk) #1 your_turn = 0;
    repeat (2) @(negedge clk);
    total++;
    if (go_rises !== g0) begin bad++; $display("FAIL pulse_no_go: got %0d acks want 0", go_rises - g0); end
    r = rand_rep(8'hE5);
    cr_report(r, ok);
    repeat (3) @(negedge clk);
    total++;
    if (!ok || {result_len, result_len_err} !== {5'd5, 1'b1}) begin
      bad++; $display("FAIL len_err: got len=%0d err=%b want 5 1", result_len, result_len_err);
    end
    total++;
    if (rep_q.size() !== n0 + 1 || rep_q[rep_q.size()-1] !== exp_rep(r)) begin
      bad++; $display("FAIL pulse_report: got %0d reports want 1", rep_q.size() - n0);
    end
    total++;
    if (match_count !== 16'd4) begin bad++; $display("FAIL pulse_match_count: got %0d want 4", match_count); end
  endtask

  task automatic test_three_hashes;
    logic [127:0] h[3];
    logic [7:0] exp_q[$];
    int base, g0, errs = 0;
    bit ok, o;
    do_reset();
    base = obs_q.size();
    g0 = go_rises;
    ok = 1;
    for (int i = 0; i < 3; i++) begin
      h[i] = {$urandom, $urandom, $urandom, $urandom};
      for (int k = 0; k < 16; k++) exp_q.push_back(h[i][8*k +: 8]);
    end
    for (int i = 0; i < 2; i++) begin
      load_hash(h[i], 0, o);
      ok &= o;
    end
    repeat (2) @(negedge clk);
    total++;
    if (go_rises !== g0 || hash_count !== 16'd2 || cracking !== 1'b0) begin
      bad++; $display("FAIL three_mid: got go=%0d hc=%0d cr=%b want 0 2 0", go_rises - g0, hash_count, cracking);
    end
    load_hash(h[2], 1, o);
    ok &= o;
    cr_go(o);
    ok &= o;
    repeat (2) @(negedge clk);
    total++;
    if (!ok || obs_q.size() - base !== 48) begin bad++; $display("FAIL three_nstores: got %0d want 48", obs_q.size() - base); end
    else begin
      for (int k = 0; k < 48; k++) if (obs_q[base+k] !== exp_q[k]) errs++;
      total++;
      if (errs != 0) begin bad++; $display("FAIL three_bytes: got %0d wrong want 0", errs); end
    end
    total++;
    if (go_rises - g0 !== 1 || hash_count !== 16'd3 || cracking !== 1'b1) begin
      bad++; $display("FAIL three_go: got go=%0d hc=%0d cr=%b want 1 3 1", go_rises - g0, hash_count, cracking);
    end
  endtask

  task automatic test_rst_mid_load;
    logic [127:0] h, h2;
    int base, errs = 0;
    bit ok, o;
    do_reset();
    h = {$urandom, $urandom, $urandom, $urandom};
    h2 = {$urandom, $urandom, $urandom, $urandom};
    send_hash(h, 1, ok);
    for (int k = 0; k < 7; k++) cr_take(o);
    @(posedge clk) #1 your_turn = 1;
    wait_out(0, 1, 50, o);
    @(posedge clk) #1;
    rst = 1; your_turn = 0;
    @(negedge clk);
    total++;
    if ({store_hash_byte, go, hash_ready, result_valid, cracking, new_hash_byte, hash_count} !== '0) begin
      bad++; $display("FAIL rst_mid: got st=%b go=%b hr=%b b=%h hc=%0d want all 0", store_hash_byte, go, hash_ready, new_hash_byte, hash_count);
    end
    @(posedge clk) #1 rst = 0;
    base = obs_q.size();
    load_hash(h2, 1, ok);
    cr_go(o);
    ok &= o;
    repeat (2) @(negedge clk);
    total++;
    if (!ok || obs_q.size() - base !== 16) begin bad++; $display("FAIL reload_nstores: got %0d want 16", obs_q.size() - base); end
    else begin
      for (int k = 0; k < 16; k++) if (obs_q[base+k] !== h2[8*k +: 8]) errs++;
      total++;
      if (errs != 0) begin bad++; $display("FAIL reload_bytes: got %0d wrong want 0", errs); end
    end
    total++;
    if (hash_count !== 16'd1 || cracking !== 1'b1) begin
      bad++; $display("FAIL reload_status: got hc=%0d cr=%b want 1 1", hash_count, cracking);
    end
  endtask

  task automatic test_invariants;
    total++;
    if (viol !== 0) begin bad++; $display("FAIL invariants: got %0d violations want 0", viol); end
  endtask

  initial begin
    test_reset();
    test_single_hash();
    test_match_abc();
    test_backpressure();
    test_ignored_pulse();
    test_three_hashes();
    test_rst_mid_load();
    test_invariants();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
